// File: rtl/gcd_operand_arb.sv
// gcd_operand_arb: N-channel valid/ready operand arbiter with one registered
// output entry, feeding the GCD datapath operand registers.
//
// Ports:
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   mode           0 = round-robin, 1 = fixed priority (channel 0 highest)
//   in_valid       per-channel operand valid
//   in_data        packed operands, channel c at [c*WIDTH +: WIDTH]
//   in_ready       per-channel accept, one-hot or zero (combinational)
//   out_valid      output register holds a word
//   out_data       selected operand
//   out_ch         source channel of out_data
//   out_zero       out_data == 0, registered alongside out_data
//   out_ready      downstream accept
module gcd_operand_arb #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N_CH  = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               mode,
    input  logic [N_CH-1:0]                    in_valid,
    input  logic [N_CH*WIDTH-1:0]              in_data,
    output logic [N_CH-1:0]                    in_ready,
    output logic                               out_valid,
    output logic [WIDTH-1:0]                   out_data,
    output logic [(N_CH > 1 ? $clog2(N_CH) : 1)-1:0] out_ch,
    output logic                               out_zero,
    input  logic                               out_ready
);

    localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [CH_W-1:0]  rr_ptr;
    logic [CH_W-1:0]  start_c;
    logic [CH_W-1:0]  cand_idx_c;
    logic [CH_W-1:0]  grant_idx_c;
    logic [CH_W-1:0]  next_ptr_c;
    logic             grant_any_c;
    logic             free_c;
    logic             xfer_c;
    logic [WIDTH-1:0] sel_data_c;
    int unsigned      cand_c;

    // Grant search: walk channels starting at start_c with wrap; first valid wins.
    // Fixed priority is simply a search that always starts at channel 0.
    always_comb begin
        free_c      = !out_valid || out_ready;
        start_c     = mode ? '0 : rr_ptr;
        grant_any_c = 1'b0;
        grant_idx_c = '0;
        cand_c      = 0;
        cand_idx_c  = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            cand_c     = (k + 32'(start_c)) % N_CH;
            cand_idx_c = CH_W'(cand_c);
            if (!grant_any_c && in_valid[cand_idx_c]) begin
                grant_any_c = 1'b1;
                grant_idx_c = cand_idx_c;
            end
        end
    end

    // Operand mux for the granted channel; non-granted data is never looked at.
    always_comb begin
        sel_data_c = '0;
        for (int unsigned c = 0; c < N_CH; c++) begin
            if (grant_idx_c == CH_W'(c)) begin
                sel_data_c = in_data[c*WIDTH +: WIDTH];
            end
        end
    end

    // Handshake: a grant is only offered when the output entry can take it,
    // and never while reset is asserted.
    always_comb begin
        xfer_c     = grant_any_c && free_c && rst_n;
        in_ready   = xfer_c ? (N_CH'(1) << grant_idx_c) : '0;
        next_ptr_c = (grant_idx_c == CH_W'(N_CH - 1)) ? '0 : grant_idx_c + CH_W'(1);
    end

    // Output entry and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            out_zero  <= 1'b0;
            rr_ptr    <= '0;
        end else if (free_c) begin
            out_valid <= xfer_c;
            if (xfer_c) begin
                out_data <= sel_data_c;
                out_ch   <= grant_idx_c;
                out_zero <= (sel_data_c == '0);
                if (!mode) begin
                    rr_ptr <= next_ptr_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_gcd_operand_arb.sv
// Self-checking bench for gcd_operand_arb: directed vector table, hand-written
// corner sequences, then randomized traffic against a queue-based reference.
module tb_gcd_operand_arb;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned N_CH  = 4;
    localparam int unsigned CH_W  = 2;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    mode;
    logic [N_CH-1:0]         in_valid;
    logic [N_CH*WIDTH-1:0]   in_data;
    logic [N_CH-1:0]         in_ready;
    logic                    out_valid;
    logic [WIDTH-1:0]        out_data;
    logic [CH_W-1:0]         out_ch;
    logic                    out_zero;
    logic                    out_ready;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gcd_operand_arb #(.WIDTH(WIDTH), .N_CH(N_CH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mode     (mode),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ch   (out_ch),
        .out_zero (out_zero),
        .out_ready(out_ready)
    );

    typedef struct {
        logic            mode;
        logic [N_CH-1:0] valid;
        logic            rdy;
        logic [N_CH-1:0] exp_ready;
        logic            exp_ov;
        logic [CH_W-1:0] exp_ch;
        logic [WIDTH-1:0] exp_data;
    } vec_t;

    typedef struct {
        logic [CH_W-1:0]  ch;
        logic [WIDTH-1:0] data;
    } word_t;

    vec_t  tbl [16];
    word_t sb [$];
    int    m_ptr;
    int    g;
    int    idx;
    bit    free_m;
    logic [N_CH-1:0] exp_rdy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic m, input logic [N_CH-1:0] v, input logic r);
        mode      = m;
        in_valid  = v;
        out_ready = r;
        #1;
    endtask

    task automatic set_ch(input int c, input logic [WIDTH-1:0] d);
        in_data[c*WIDTH +: WIDTH] = d;
    endtask

    initial begin
        // Rotation, fixed priority, mode switch back to round-robin, then idle.
        tbl[0]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h12};
        tbl[1]  = '{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h34};
        tbl[2]  = '{1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h56};
        tbl[3]  = '{1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h78};
        tbl[4]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h12};
        tbl[5]  = '{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h34};
        tbl[6]  = '{1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h56};
        tbl[7]  = '{1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h78};
        tbl[8]  = '{1'b1, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h34};
        tbl[9]  = '{1'b1, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h34};
        tbl[10] = '{1'b1, 4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h78};
        tbl[11] = '{1'b0, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h34};
        tbl[12] = '{1'b0, 4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h78};
        tbl[13] = '{1'b0, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h34};
        tbl[14] = '{1'b0, 4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h78};
        tbl[15] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3, 8'h78};

        // Reset values with every channel requesting.
        rst_n     = 1'b0;
        mode      = 1'b0;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        in_data   = {8'h78, 8'h56, 8'h34, 8'h12};
        #2;
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_out_ch", 32'(out_ch), 32'h0);
        chk("rst_out_zero", 32'(out_zero), 32'h0);
        tick();
        tick();
        chk("rst_hold_out_valid", 32'(out_valid), 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].mode, tbl[i].valid, tbl[i].rdy);
            chk($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].exp_ready));
            tick();
            chk($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].exp_ov));
            chk($sformatf("tbl%0d_out_ch", i), 32'(out_ch), 32'(tbl[i].exp_ch));
            chk($sformatf("tbl%0d_out_data", i), 32'(out_data), 32'(tbl[i].exp_data));
        end

        // Back-pressure: ch2 loaded (pointer moves to 3), then held 5 cycles.
        set_ch(2, 8'hA5);
        drive(1'b0, 4'b0100, 1'b1);
        chk("bp_load_in_ready", 32'(in_ready), 32'h4);
        tick();
        chk("bp_load_data", 32'(out_data), 32'hA5);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 4'b0100, 1'b0);
            chk($sformatf("bp%0d_in_ready", i), 32'(in_ready), 32'h0);
            chk($sformatf("bp%0d_out_valid", i), 32'(out_valid), 32'h1);
            chk($sformatf("bp%0d_out_data", i), 32'(out_data), 32'hA5);
            chk($sformatf("bp%0d_out_ch", i), 32'(out_ch), 32'h2);
            if (i == 1) set_ch(2, 8'h5A);
            tick();
        end
        drive(1'b0, 4'b0100, 1'b1);
        chk("bp_refill_in_ready", 32'(in_ready), 32'h4);
        tick();
        chk("bp_refill_valid", 32'(out_valid), 32'h1);
        chk("bp_refill_data", 32'(out_data), 32'h5A);
        drive(1'b0, 4'b0000, 1'b1);
        tick();
        chk("bp_drain_valid", 32'(out_valid), 32'h0);

        // Zero flag and pointer wrap: pointer sits at 3 after serving ch2.
        set_ch(3, 8'h00);
        set_ch(0, 8'hFF);
        drive(1'b0, 4'b1001, 1'b1);
        chk("wrap_first_in_ready", 32'(in_ready), 32'h8);
        tick();
        chk("wrap_zero_ch", 32'(out_ch), 32'h3);
        chk("wrap_zero_flag", 32'(out_zero), 32'h1);
        drive(1'b0, 4'b1001, 1'b1);
        chk("wrap_second_in_ready", 32'(in_ready), 32'h1);
        tick();
        chk("wrap_ff_ch", 32'(out_ch), 32'h0);
        chk("wrap_ff_flag", 32'(out_zero), 32'h0);
        chk("wrap_ff_data", 32'(out_data), 32'hFF);
        drive(1'b0, 4'b0000, 1'b1);
        tick();

        // Mid-operation reset with a held word; pointer is 1 before, 2 after load.
        set_ch(1, 8'h3C);
        drive(1'b0, 4'b0010, 1'b0);
        tick();
        chk("mr_loaded_valid", 32'(out_valid), 32'h1);
        chk("mr_loaded_data", 32'(out_data), 32'h3C);
        drive(1'b0, 4'b0000, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_async_valid", 32'(out_valid), 32'h0);
        chk("mr_async_data", 32'(out_data), 32'h0);
        chk("mr_async_ch", 32'(out_ch), 32'h0);
        chk("mr_async_zero", 32'(out_zero), 32'h0);
        in_valid = 4'b1010;
        #1;
        chk("mr_in_ready_in_reset", 32'(in_ready), 32'h0);
        tick();
        rst_n = 1'b1;
        set_ch(1, 8'h77);
        drive(1'b0, 4'b1010, 1'b1);
        chk("mr_ptr_cleared_in_ready", 32'(in_ready), 32'h2);
        tick();
        chk("mr_new_ch", 32'(out_ch), 32'h1);
        chk("mr_new_data", 32'(out_data), 32'h77);
        drive(1'b0, 4'b0000, 1'b1);
        tick();
        chk("mr_drain_valid", 32'(out_valid), 32'h0);

        // Randomized traffic against a scoreboard of accepted words.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        sb.delete();
        m_ptr = 0;
        mode  = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            in_valid = N_CH'($urandom);
            for (int c = 0; c < N_CH; c++) begin
                in_data[c*WIDTH +: WIDTH] = ($urandom_range(0, 3) == 0) ? '0 : WIDTH'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            free_m = (sb.size() == 0) || out_ready;
            g = -1;
            for (int k = 0; k < N_CH; k++) begin
                idx = mode ? k : (m_ptr + k) % N_CH;
                if (g < 0 && in_valid[idx]) g = idx;
            end
            exp_rdy = (free_m && g >= 0) ? N_CH'(1 << g) : '0;
            chk("rand_in_ready", 32'(in_ready), 32'(exp_rdy));
            chk("rand_out_valid", 32'(out_valid), 32'(sb.size() != 0));
            if (sb.size() != 0) begin
                chk("rand_out_data", 32'(out_data), 32'(sb[0].data));
                chk("rand_out_ch", 32'(out_ch), 32'(sb[0].ch));
                chk("rand_out_zero", 32'(out_zero), 32'(sb[0].data == '0));
            end
            if (free_m) begin
                if (sb.size() != 0) sb.delete(0);
                if (g >= 0) begin
                    sb.push_back('{CH_W'(g), in_data[g*WIDTH +: WIDTH]});
                    if (!mode) m_ptr = (g + 1) % N_CH;
                end
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
